// File: rtl/disassembler.sv
// disassembler: receive-side header stripper for the CGRA vector-stream-in path.
// Strips the header_deg-lane header from a packet's first beat, realigns the payload
// to lane 0, exposes the header and its SPL field, and checks the IPv4 header checksum.
// Latency: data 1 cycle; hdr_valid 1 cycle after the first beat; csum_valid 5 cycles
// after it (1 cycle, coincident with hdr_valid, when the checksum tree is not built).
// No backpressure: every present beat (tvalid_in[0]) is consumed in the cycle it arrives.
//
// Ports:
//   clk, rst (async, active-high)    clock / reset
//   is_vstreamin_global              strip enable, sampled on a packet's first beat
//   tdata_in/tvalid_in/tlast_in      input beat, per-lane valid, replicated last
//   tdata_out/tvalid_out/tlast_out   realigned output beat (registered)
//   header_out, spl_out, hdr_valid   captured header, its length field, update pulse
//   csum_ok, csum_valid              checksum result and its qualifying pulse
//
// Build option: define DISASM_CSUM_CHECK_EN to compile in the checksum adder tree.
// Without it csum_valid follows hdr_valid and csum_ok reads 1.
module disassembler #(
    parameter int phit_size   = 512,
    parameter int SIMD_degree = 16,
    parameter int header_deg  = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     is_vstreamin_global,
    input  logic [phit_size-1:0]     tdata_in,
    input  logic [SIMD_degree-1:0]   tvalid_in,
    input  logic [SIMD_degree-1:0]   tlast_in,
    output logic [phit_size-1:0]     tdata_out,
    output logic [SIMD_degree-1:0]   tvalid_out,
    output logic [SIMD_degree-1:0]   tlast_out,
    output logic [header_deg*32-1:0] header_out,
    output logic [15:0]              spl_out,
    output logic                     hdr_valid,
    output logic                     csum_ok,
    output logic                     csum_valid
);

    localparam int P  = SIMD_degree - header_deg;   // payload lanes left in the first beat
    localparam int HW = header_deg * 32;
    localparam int PW = P * 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BODY,
        ST_FLUSH,
        ST_PASS
    } state_t;

    state_t                  r_state;
    logic [PW-1:0]           r_hold_dat;
    logic [P-1:0]            r_hold_vld;
    logic                    r_pending;
    logic [phit_size-1:0]    r_tdata;
    logic [SIMD_degree-1:0]  r_tvalid;
    logic [SIMD_degree-1:0]  r_tlast;
    logic [HW-1:0]           r_header;
    logic                    r_hdr_valid;
    logic                    r_csum_ok;
    logic                    r_csum_valid;

    logic                    w_present;
    logic                    w_last;
    logic                    w_first;
    logic                    w_hdr_load;
    logic                    w_flush_now;
    logic [SIMD_degree-2:0]  w_unused_tlast;

    assign w_present      = tvalid_in[0];
    // tlast is replicated across lanes; lane 0 is representative.
    assign w_last         = tlast_in[0];
    assign w_unused_tlast = tlast_in[SIMD_degree-1:1];
    // FLUSH accepts a new first beat exactly like IDLE, so packets can abut.
    assign w_first        = (r_state == ST_IDLE) || (r_state == ST_FLUSH);
    assign w_hdr_load     = w_first && w_present && is_vstreamin_global;
    assign w_flush_now    = (r_state == ST_FLUSH) && r_pending;

    assign tdata_out  = r_tdata;
    assign tvalid_out = r_tvalid;
    assign tlast_out  = r_tlast;
    assign header_out = r_header;
    assign spl_out    = r_header[127:112];
    assign hdr_valid  = r_hdr_valid;
    assign csum_ok    = r_csum_ok;
    assign csum_valid = r_csum_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_hold_dat  <= '0;
            r_hold_vld  <= '0;
            r_pending   <= 1'b0;
            r_tdata     <= '0;
            r_tvalid    <= '0;
            r_tlast     <= '0;
            r_header    <= '0;
            r_hdr_valid <= 1'b0;
        end else begin
            // Output is a single-cycle beat; idle cycles show an all-zero bus.
            r_tdata     <= '0;
            r_tvalid    <= '0;
            r_tlast     <= '0;
            r_hdr_valid <= 1'b0;

            // Tail of the previous stripped packet; a header-only packet leaves nothing.
            if (w_flush_now) begin
                r_tdata   <= {{HW{1'b0}}, r_hold_dat};
                r_tvalid  <= {{header_deg{1'b0}}, r_hold_vld};
                r_tlast   <= '1;
                r_pending <= 1'b0;
            end

            case (r_state)
                ST_IDLE, ST_FLUSH: begin
                    r_state <= ST_IDLE;
                    if (w_present) begin
                        if (is_vstreamin_global) begin
                            r_header    <= tdata_in[HW-1:0];
                            r_hdr_valid <= 1'b1;
                            r_hold_dat  <= tdata_in[phit_size-1:HW];
                            r_hold_vld  <= tvalid_in[SIMD_degree-1:header_deg];
                            r_pending   <= |tvalid_in[SIMD_degree-1:header_deg];
                            r_state     <= w_last ? ST_FLUSH : ST_BODY;
                        end else begin
                            // An unstripped beat abutting a non-empty flush cannot share
                            // the single output register; the flush beat keeps it.
                            if (!w_flush_now) begin
                                r_tdata  <= tdata_in;
                                r_tvalid <= tvalid_in;
                                r_tlast  <= tlast_in;
                            end
                            r_state <= w_last ? ST_IDLE : ST_PASS;
                        end
                    end
                end

                ST_BODY: begin
                    if (w_present) begin
                        r_tdata    <= {tdata_in[HW-1:0], r_hold_dat};
                        r_tvalid   <= {tvalid_in[header_deg-1:0], r_hold_vld};
                        r_hold_dat <= tdata_in[phit_size-1:HW];
                        r_hold_vld <= tvalid_in[SIMD_degree-1:header_deg];
                        r_pending  <= |tvalid_in[SIMD_degree-1:header_deg];
                        if (w_last) begin
                            // Lanes beyond header_deg spill into one more beat.
                            if (tvalid_in[header_deg]) begin
                                r_state <= ST_FLUSH;
                            end else begin
                                r_tlast <= '1;
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                end

                ST_PASS: begin
                    if (w_present) begin
                        r_tdata  <= tdata_in;
                        r_tvalid <= tvalid_in;
                        r_tlast  <= tlast_in;
                        if (w_last) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef DISASM_CSUM_CHECK_EN
    // Ten 16-bit IPv4 header words sit at header bits [271:112]; the tree starts
    // from the input beat so the first add stage lines up with the header capture.
    logic [15:0] w_word [10];
    logic [19:0] r_s1 [5];
    logic [19:0] r_s2 [3];
    logic [19:0] r_s3 [2];
    logic [19:0] r_s4;
    logic [3:0]  r_cv;
    logic [19:0] w_fold1;
    logic [15:0] w_fold2;

    always_comb begin
        for (int k = 0; k < 10; k++) begin
            w_word[k] = tdata_in[16*k+112 +: 16];
        end
    end

    // Two end-around folds: the second absorbs the carry the first can create.
    assign w_fold1 = {4'b0, r_s4[15:0]} + {16'b0, r_s4[19:16]};
    assign w_fold2 = w_fold1[15:0] + {12'b0, w_fold1[19:16]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) r_s1[i] <= '0;
            for (int i = 0; i < 3; i++) r_s2[i] <= '0;
            for (int i = 0; i < 2; i++) r_s3[i] <= '0;
            r_s4         <= '0;
            r_cv         <= '0;
            r_csum_ok    <= 1'b0;
            r_csum_valid <= 1'b0;
        end else begin
            r_cv <= {r_cv[2:0], w_hdr_load};
            for (int i = 0; i < 5; i++) begin
                r_s1[i] <= {4'b0, w_word[2*i]} + {4'b0, w_word[2*i+1]};
            end
            r_s2[0]      <= r_s1[0] + r_s1[1];
            r_s2[1]      <= r_s1[2] + r_s1[3];
            r_s2[2]      <= r_s1[4];
            r_s3[0]      <= r_s2[0] + r_s2[1];
            r_s3[1]      <= r_s2[2];
            r_s4         <= r_s3[0] + r_s3[1];
            r_csum_valid <= r_cv[3];
            if (r_cv[3]) begin
                r_csum_ok <= (w_fold2 == 16'hFFFF);
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csum_ok    <= 1'b0;
            r_csum_valid <= 1'b0;
        end else begin
            r_csum_valid <= w_hdr_load;
            if (w_hdr_load) begin
                r_csum_ok <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_disassembler.sv
module tb_disassembler;

    localparam int S  = 16;
    localparam int HD = 10;
    localparam int W  = 512;
`ifdef DISASM_CSUM_CHECK_EN
    localparam bit CSUM_EN  = 1'b1;
    localparam int CSUM_LAT = 5;
`else
    localparam bit CSUM_EN  = 1'b0;
    localparam int CSUM_LAT = 1;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            strip;
    logic [W-1:0]    tdata_in;
    logic [S-1:0]    tvalid_in;
    logic [S-1:0]    tlast_in;
    logic [W-1:0]    tdata_out;
    logic [S-1:0]    tvalid_out;
    logic [S-1:0]    tlast_out;
    logic [HD*32-1:0] header_out;
    logic [15:0]     spl_out;
    logic            hdr_valid;
    logic            csum_ok;
    logic            csum_valid;

    disassembler dut (
        .clk                 (clk),
        .rst                 (rst),
        .is_vstreamin_global (strip),
        .tdata_in            (tdata_in),
        .tvalid_in           (tvalid_in),
        .tlast_in            (tlast_in),
        .tdata_out           (tdata_out),
        .tvalid_out          (tvalid_out),
        .tlast_out           (tlast_out),
        .header_out          (header_out),
        .spl_out             (spl_out),
        .hdr_valid           (hdr_valid),
        .csum_ok             (csum_ok),
        .csum_valid          (csum_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Observed traffic, sampled on the falling edge.
    logic [W-1:0]     ob_dat[$];
    logic [S-1:0]     ob_vld[$];
    logic [S-1:0]     ob_lst[$];
    int               ob_cyc[$];
    logic [HD*32-1:0] hv_hdr[$];
    logic [15:0]      hv_spl[$];
    int               hv_cyc[$];
    logic             cv_ok[$];
    int               cv_cyc[$];

    // Expected traffic from the reference model.
    logic [W-1:0]     ex_dat[$];
    logic [S-1:0]     ex_vld[$];
    logic [S-1:0]     ex_lst[$];
    logic [HD*32-1:0] ex_hdr[$];
    int               ex_hcyc[$];
    logic             ex_ok[$];
    int               ex_ccyc[$];

    logic [31:0]      pk[$];   // valid lanes of the packet being built

    always @(negedge clk) begin
        if (tvalid_out[0]) begin
            ob_dat.push_back(tdata_out);
            ob_vld.push_back(tvalid_out);
            ob_lst.push_back(tlast_out);
            ob_cyc.push_back(cyc);
        end
        if (hdr_valid) begin
            hv_hdr.push_back(header_out);
            hv_spl.push_back(spl_out);
            hv_cyc.push_back(cyc);
        end
        if (csum_valid) begin
            cv_ok.push_back(csum_ok);
            cv_cyc.push_back(cyc);
        end
    end

    task automatic clear_q();
        ob_dat.delete(); ob_vld.delete(); ob_lst.delete(); ob_cyc.delete();
        hv_hdr.delete(); hv_spl.delete(); hv_cyc.delete();
        cv_ok.delete();  cv_cyc.delete();
        ex_dat.delete(); ex_vld.delete(); ex_lst.delete();
        ex_hdr.delete(); ex_hcyc.delete(); ex_ok.delete(); ex_ccyc.delete();
    endtask

    task automatic drive(input logic [W-1:0] d, input logic [S-1:0] v, input logic l, input logic s);
        @(posedge clk);
        #1;
        tdata_in  = d;
        tvalid_in = v;
        tlast_in  = {S{l}};
        strip     = s;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            tdata_in  = '0;
            tvalid_in = '0;
            tlast_in  = '0;
            strip     = 1'b0;
        end
    endtask

    task automatic build_pkt(input int n);
        pk.delete();
        for (int i = 0; i < n; i++) pk.push_back($urandom);
    endtask

    // Sends pk as full beats with a partial last beat; returns the first beat's cycle.
    task automatic send_pkt(input logic s, output int first_cyc);
        logic [W-1:0] d;
        logic [S-1:0] v;
        int nb;
        nb = (pk.size() + S - 1) / S;
        first_cyc = 0;
        for (int b = 0; b < nb; b++) begin
            d = '0;
            v = '0;
            for (int j = 0; j < S; j++) begin
                if (b*S + j < pk.size()) begin
                    d[32*j +: 32] = pk[b*S + j];
                    v[j] = 1'b1;
                end
            end
            drive(d, v, b == nb-1, s);
            if (b == 0) first_cyc = cyc;
        end
    endtask

    // One's-complement sum of the ten IPv4 words; a good header sums to 0xFFFF.
    function automatic logic ref_csum(input logic [HD*32-1:0] h);
        int unsigned s;
        s = 0;
        for (int k = 0; k < 10; k++) s += h[16*k+112 +: 16];
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return s == 32'hFFFF;
    endfunction

    // Packet-level model: a stripped packet is its lane list minus the first HD
    // lanes, re-chunked into S-lane beats; an unstripped packet is unchanged.
    task automatic model_pkt(input logic s, input int first_cyc);
        logic [HD*32-1:0] h;
        logic [W-1:0] d;
        logic [S-1:0] v;
        int base, n;
        base = 0;
        if (s) begin
            h = '0;
            for (int i = 0; i < HD; i++) h[32*i +: 32] = pk[i];
            ex_hdr.push_back(h);
            ex_hcyc.push_back(first_cyc + 1);
            ex_ok.push_back(CSUM_EN ? ref_csum(h) : 1'b1);
            ex_ccyc.push_back(first_cyc + CSUM_LAT);
            base = HD;
        end
        n = pk.size() - base;
        for (int c = 0; c < n; c += S) begin
            d = '0;
            v = '0;
            for (int j = 0; j < S && c + j < n; j++) begin
                d[32*j +: 32] = pk[base + c + j];
                v[j] = 1'b1;
            end
            ex_dat.push_back(d);
            ex_vld.push_back(v);
            ex_lst.push_back((c + S >= n) ? {S{1'b1}} : {S{1'b0}});
        end
    endtask

    task automatic test_reset();
        checks++; if (tdata_out !== '0)  begin errors++; $display("FAIL reset_tdata got %h exp 0", tdata_out); end
        checks++; if (tvalid_out !== '0) begin errors++; $display("FAIL reset_tvalid got %h exp 0", tvalid_out); end
        checks++; if (tlast_out !== '0)  begin errors++; $display("FAIL reset_tlast got %h exp 0", tlast_out); end
        checks++; if (header_out !== '0) begin errors++; $display("FAIL reset_header got %h exp 0", header_out); end
        checks++; if (spl_out !== '0)    begin errors++; $display("FAIL reset_spl got %h exp 0", spl_out); end
        checks++; if (hdr_valid !== 1'b0) begin errors++; $display("FAIL reset_hdr_valid got %b exp 0", hdr_valid); end
        checks++; if (csum_ok !== 1'b0)  begin errors++; $display("FAIL reset_csum_ok got %b exp 0", csum_ok); end
        checks++; if (csum_valid !== 1'b0) begin errors++; $display("FAIL reset_csum_valid got %b exp 0", csum_valid); end
    endtask

    task automatic test_three_beats();
        int fc, nl;
        logic [W-1:0] ed;
        logic [S-1:0] ev, el;
        logic [HD*32-1:0] eh;
        clear_q();
        pk.delete();
        for (int i = 0; i < 48; i++) pk.push_back(32'(i));   // lane i of beat b = 16b+i
        send_pkt(1'b1, fc);
        idle(6);
        checks++;
        if (ob_dat.size() != 3) begin errors++; $display("FAIL three_beats_count got %0d exp 3", ob_dat.size()); end
        for (int b = 0; b < 3 && b < ob_dat.size(); b++) begin
            nl = (b < 2) ? 16 : 6;
            ed = '0;
            for (int j = 0; j < nl; j++) ed[32*j +: 32] = 32'(10 + 16*b + j);
            ev = (b < 2) ? 16'hFFFF : 16'h003F;
            el = (b == 2) ? 16'hFFFF : 16'h0000;
            checks++; if (ob_dat[b] !== ed) begin errors++; $display("FAIL three_beats_dat[%0d] got %h exp %h", b, ob_dat[b], ed); end
            checks++; if (ob_vld[b] !== ev) begin errors++; $display("FAIL three_beats_vld[%0d] got %h exp %h", b, ob_vld[b], ev); end
            checks++; if (ob_lst[b] !== el) begin errors++; $display("FAIL three_beats_lst[%0d] got %h exp %h", b, ob_lst[b], el); end
            checks++; if (ob_cyc[b] !== fc + 2 + b) begin errors++; $display("FAIL three_beats_cyc[%0d] got %0d exp %0d", b, ob_cyc[b], fc + 2 + b); end
        end
        eh = '0;
        for (int i = 0; i < HD; i++) eh[32*i +: 32] = 32'(i);
        checks++;
        if (hv_hdr.size() != 1) begin
            errors++; $display("FAIL three_beats_hdr_count got %0d exp 1", hv_hdr.size());
        end else begin
            checks++; if (hv_hdr[0] !== eh) begin errors++; $display("FAIL three_beats_hdr got %h exp %h", hv_hdr[0], eh); end
            checks++; if (hv_spl[0] !== eh[127:112]) begin errors++; $display("FAIL three_beats_spl got %h exp %h", hv_spl[0], eh[127:112]); end
            checks++; if (hv_cyc[0] !== fc + 1) begin errors++; $display("FAIL three_beats_hdr_cyc got %0d exp %0d", hv_cyc[0], fc + 1); end
        end
    endtask

    task automatic test_short_last();
        int fc;
        logic [W-1:0] ed;
        clear_q();
        build_pkt(24);   // full first beat, 8-lane last beat
        send_pkt(1'b1, fc);
        idle(6);
        ed = '0;
        for (int j = 0; j < 14; j++) ed[32*j +: 32] = pk[HD + j];
        checks++;
        if (ob_dat.size() != 1) begin
            errors++; $display("FAIL short_last_count got %0d exp 1", ob_dat.size());
        end else begin
            checks++; if (ob_dat[0] !== ed) begin errors++; $display("FAIL short_last_dat got %h exp %h", ob_dat[0], ed); end
            checks++; if (ob_vld[0] !== 16'h3FFF) begin errors++; $display("FAIL short_last_vld got %h exp 3fff", ob_vld[0]); end
            checks++; if (ob_lst[0] !== 16'hFFFF) begin errors++; $display("FAIL short_last_lst got %h exp ffff", ob_lst[0]); end
            checks++; if (ob_cyc[0] !== fc + 2) begin errors++; $display("FAIL short_last_cyc got %0d exp %0d", ob_cyc[0], fc + 2); end
        end
    endtask

    task automatic test_back_to_back();
        int fa, fb;
        clear_q();
        build_pkt(32);          // A: ends with a 6-lane flush
        send_pkt(1'b1, fa);
        model_pkt(1'b1, fa);
        build_pkt(40);          // B: first beat lands in A's FLUSH cycle
        send_pkt(1'b1, fb);
        model_pkt(1'b1, fb);
        idle(10);
        checks++; if (fb !== fa + 2) begin errors++; $display("FAIL b2b_abut got %0d exp %0d", fb, fa + 2); end
        checks++; if (ob_dat.size() != ex_dat.size()) begin errors++; $display("FAIL b2b_beat_count got %0d exp %0d", ob_dat.size(), ex_dat.size()); end
        for (int i = 0; i < ob_dat.size() && i < ex_dat.size(); i++) begin
            checks++;
            if (ob_dat[i] !== ex_dat[i] || ob_vld[i] !== ex_vld[i] || ob_lst[i] !== ex_lst[i]) begin
                errors++;
                $display("FAIL b2b_beat[%0d] got vld=%h lst=%h dat=%h exp vld=%h lst=%h dat=%h", i, ob_vld[i], ob_lst[i], ob_dat[i], ex_vld[i], ex_lst[i], ex_dat[i]);
            end
        end
        checks++; if (hv_hdr.size() != ex_hdr.size()) begin errors++; $display("FAIL b2b_hdr_count got %0d exp %0d", hv_hdr.size(), ex_hdr.size()); end
        for (int i = 0; i < hv_hdr.size() && i < ex_hdr.size(); i++) begin
            checks++; if (hv_hdr[i] !== ex_hdr[i]) begin errors++; $display("FAIL b2b_hdr[%0d] got %h exp %h", i, hv_hdr[i], ex_hdr[i]); end
            checks++; if (hv_cyc[i] !== ex_hcyc[i]) begin errors++; $display("FAIL b2b_hdr_cyc[%0d] got %0d exp %0d", i, hv_cyc[i], ex_hcyc[i]); end
        end
    endtask

    task automatic test_checksum();
        logic [HD*32-1:0] h;
        int unsigned s;
        int fc;
        logic eok;
        for (int pass = 0; pass < 2; pass++) begin
            clear_q();
            for (int i = 0; i < HD; i++) h[32*i +: 32] = $urandom;
            s = 0;
            for (int k = 0; k < 10; k++) if (k != 5) s += h[16*k+112 +: 16];
            while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
            h[16*5+112 +: 16] = ~s[15:0];
            if (pass == 1) h[150] = ~h[150];
            pk.delete();
            for (int i = 0; i < HD; i++) pk.push_back(h[32*i +: 32]);
            for (int i = HD; i < S; i++) pk.push_back($urandom);
            send_pkt(1'b1, fc);
            idle(10);
            eok = (pass == 0) ? 1'b1 : !CSUM_EN;
            checks++;
            if (cv_ok.size() != 1) begin
                errors++; $display("FAIL csum_count[%0d] got %0d exp 1", pass, cv_ok.size());
            end else begin
                checks++; if (cv_ok[0] !== eok) begin errors++; $display("FAIL csum_ok[%0d] got %b exp %b", pass, cv_ok[0], eok); end
                checks++; if (cv_cyc[0] !== fc + CSUM_LAT) begin errors++; $display("FAIL csum_cyc[%0d] got %0d exp %0d", pass, cv_cyc[0], fc + CSUM_LAT); end
            end
        end
    endtask

    task automatic test_passthrough();
        logic [W-1:0] d0, d1;
        int fc;
        clear_q();
        for (int j = 0; j < S; j++) begin d0[32*j +: 32] = $urandom; d1[32*j +: 32] = $urandom; end
        drive(d0, 16'hFFFF, 1'b0, 1'b0);
        fc = cyc;
        drive(d1, 16'h00FF, 1'b1, 1'b0);
        idle(8);
        checks++;
        if (ob_dat.size() != 2) begin
            errors++; $display("FAIL pass_count got %0d exp 2", ob_dat.size());
        end else begin
            checks++; if (ob_dat[0] !== d0) begin errors++; $display("FAIL pass_dat0 got %h exp %h", ob_dat[0], d0); end
            checks++; if (ob_vld[0] !== 16'hFFFF || ob_lst[0] !== 16'h0000) begin errors++; $display("FAIL pass_ctl0 got vld=%h lst=%h exp ffff 0000", ob_vld[0], ob_lst[0]); end
            checks++; if (ob_cyc[0] !== fc + 1) begin errors++; $display("FAIL pass_cyc0 got %0d exp %0d", ob_cyc[0], fc + 1); end
            checks++; if (ob_dat[1] !== d1) begin errors++; $display("FAIL pass_dat1 got %h exp %h", ob_dat[1], d1); end
            checks++; if (ob_vld[1] !== 16'h00FF || ob_lst[1] !== 16'hFFFF) begin errors++; $display("FAIL pass_ctl1 got vld=%h lst=%h exp 00ff ffff", ob_vld[1], ob_lst[1]); end
        end
        checks++; if (hv_hdr.size() != 0) begin errors++; $display("FAIL pass_hdr_valid got %0d pulses exp 0", hv_hdr.size()); end
        checks++; if (cv_ok.size() != 0) begin errors++; $display("FAIL pass_csum_valid got %0d pulses exp 0", cv_ok.size()); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d0, d1, ed;
        int fc;
        for (int j = 0; j < S; j++) begin d0[32*j +: 32] = $urandom; d1[32*j +: 32] = $urandom; end
        drive(d0, 16'hFFFF, 1'b0, 1'b1);
        drive(d1, 16'hFFFF, 1'b0, 1'b1);
        idle(1);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (tvalid_out !== '0 || tlast_out !== '0) begin errors++; $display("FAIL rst_mid_ctl got vld=%h lst=%h exp 0", tvalid_out, tlast_out); end
        checks++; if (tdata_out !== '0) begin errors++; $display("FAIL rst_mid_dat got %h exp 0", tdata_out); end
        checks++; if (header_out !== '0 || spl_out !== '0) begin errors++; $display("FAIL rst_mid_hdr got %h exp 0", header_out); end
        @(negedge clk);
        rst = 1'b0;
        clear_q();
        build_pkt(32);
        send_pkt(1'b1, fc);
        idle(6);
        checks++;
        if (ob_dat.size() != 2) begin
            errors++; $display("FAIL rst_mid_count got %0d exp 2", ob_dat.size());
        end else begin
            ed = '0;
            for (int j = 0; j < S; j++) ed[32*j +: 32] = pk[HD + j];
            checks++; if (ob_dat[0] !== ed || ob_vld[0] !== 16'hFFFF) begin errors++; $display("FAIL rst_mid_beat0 got vld=%h dat=%h exp ffff %h", ob_vld[0], ob_dat[0], ed); end
            ed = '0;
            for (int j = 0; j < 6; j++) ed[32*j +: 32] = pk[HD + S + j];
            checks++; if (ob_dat[1] !== ed || ob_vld[1] !== 16'h003F || ob_lst[1] !== 16'hFFFF) begin errors++; $display("FAIL rst_mid_beat1 got vld=%h lst=%h dat=%h exp 003f ffff %h", ob_vld[1], ob_lst[1], ob_dat[1], ed); end
        end
    endtask

    task automatic test_random();
        int fc, nb, nl, gap;
        logic s, prev_s;
        clear_q();
        prev_s = 1'b0;
        for (int p = 0; p < 24; p++) begin
            s  = ($urandom_range(0, 3) != 0);
            nb = $urandom_range(1, 3);
            if (nb == 1) nl = $urandom_range(s ? HD : 1, S);
            else         nl = S*(nb-1) + $urandom_range(1, S);
            gap = $urandom_range(0, 2);
            // An unstripped packet needs a gap after a stripped one's flush cycle.
            if (!s && prev_s && gap == 0) gap = 1;
            if (gap > 0) idle(gap);
            build_pkt(nl);
            send_pkt(s, fc);
            model_pkt(s, fc);
            prev_s = s;
        end
        idle(12);
        checks++; if (ob_dat.size() != ex_dat.size()) begin errors++; $display("FAIL rand_beat_count got %0d exp %0d", ob_dat.size(), ex_dat.size()); end
        for (int i = 0; i < ob_dat.size() && i < ex_dat.size(); i++) begin
            checks++;
            if (ob_dat[i] !== ex_dat[i] || ob_vld[i] !== ex_vld[i] || ob_lst[i] !== ex_lst[i]) begin
                errors++;
                $display("FAIL rand_beat[%0d] got vld=%h lst=%h dat=%h exp vld=%h lst=%h dat=%h", i, ob_vld[i], ob_lst[i], ob_dat[i], ex_vld[i], ex_lst[i], ex_dat[i]);
            end
        end
        checks++; if (hv_hdr.size() != ex_hdr.size()) begin errors++; $display("FAIL rand_hdr_count got %0d exp %0d", hv_hdr.size(), ex_hdr.size()); end
        for (int i = 0; i < hv_hdr.size() && i < ex_hdr.size(); i++) begin
            checks++; if (hv_hdr[i] !== ex_hdr[i]) begin errors++; $display("FAIL rand_hdr[%0d] got %h exp %h", i, hv_hdr[i], ex_hdr[i]); end
            checks++; if (hv_spl[i] !== ex_hdr[i][127:112]) begin errors++; $display("FAIL rand_spl[%0d] got %h exp %h", i, hv_spl[i], ex_hdr[i][127:112]); end
            checks++; if (hv_cyc[i] !== ex_hcyc[i]) begin errors++; $display("FAIL rand_hdr_cyc[%0d] got %0d exp %0d", i, hv_cyc[i], ex_hcyc[i]); end
        end
        checks++; if (cv_ok.size() != ex_ok.size()) begin errors++; $display("FAIL rand_csum_count got %0d exp %0d", cv_ok.size(), ex_ok.size()); end
        for (int i = 0; i < cv_ok.size() && i < ex_ok.size(); i++) begin
            checks++; if (cv_ok[i] !== ex_ok[i]) begin errors++; $display("FAIL rand_csum_ok[%0d] got %b exp %b", i, cv_ok[i], ex_ok[i]); end
            checks++; if (cv_cyc[i] !== ex_ccyc[i]) begin errors++; $display("FAIL rand_csum_cyc[%0d] got %0d exp %0d", i, cv_cyc[i], ex_ccyc[i]); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        strip     = 1'b0;
        tdata_in  = '0;
        tvalid_in = '0;
        tlast_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        test_three_beats();
        test_short_last();
        test_back_to_back();
        test_checksum();
        test_passthrough();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
